// File: rtl/amp_out_discriminator.sv
// amp_out_discriminator
//   Turns the asynchronous op-amp OUT level into one clock-synchronous trigger
//   pulse per qualified rising excursion. A holdoff window follows each pulse,
//   and the input must return low before the next excursion can qualify.
//   Accepted triggers are counted with a saturating counter and a sticky
//   overflow flag.
//
// Ports
//   CLK       system clock, all state on the rising edge
//   RST       synchronous active-high reset
//   AMP_IN    op-amp OUT level, asynchronous to CLK
//   ENABLE    1 = armed; 0 = force IDLE, no triggers
//   CNT_CLR   synchronous clear of EVT_CNT and OVF
//   TRIG_OUT  registered trigger pulse, PULSE_LEN cycles per event
//   BUSY      high in FIRE, HOLDOFF or REARM
//   EVT_CNT   accepted-event count, saturating
//   OVF       sticky, set when an event arrives while EVT_CNT is all ones
module amp_out_discriminator #(
  parameter int unsigned MIN_WIDTH = 3,
  parameter int unsigned PULSE_LEN = 4,
  parameter int unsigned HOLDOFF   = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             AMP_IN,
  input  logic             ENABLE,
  input  logic             CNT_CLR,
  output logic             TRIG_OUT,
  output logic             BUSY,
  output logic [CNT_W-1:0] EVT_CNT,
  output logic             OVF
);

  localparam int unsigned QW = $clog2(MIN_WIDTH + 1);
  localparam int unsigned PW = $clog2(PULSE_LEN + 1);
  localparam int unsigned HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  localparam logic [QW-1:0] QLast = QW'(MIN_WIDTH - 1);
  localparam logic [PW-1:0] PLast = PW'(PULSE_LEN - 1);
  localparam logic [HW-1:0] HLast = (HOLDOFF > 0) ? HW'(HOLDOFF - 1) : '0;

  typedef enum logic [2:0] {
    StIdle,
    StQual,
    StFire,
    StHoldoff,
    StRearm
  } state_e;

  state_e          state_q, state_d;
  logic [QW-1:0]   qcnt_q, qcnt_d;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic            s1_q, s_in_q;
  logic            trig_q, busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic            ovf_q;
  logic            fire_evt;

  // Two-flop synchronizer; only s_in_q is used downstream.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_q   <= 1'b0;
      s_in_q <= 1'b0;
    end else begin
      s1_q   <= AMP_IN;
      s_in_q <= s1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    pcnt_d  = pcnt_q;
    hcnt_d  = hcnt_q;
    if (!ENABLE) begin
      // Disarm truncates any pulse in progress and clears the phase counters.
      state_d = StIdle;
      qcnt_d  = '0;
      pcnt_d  = '0;
      hcnt_d  = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (s_in_q) begin
            if (MIN_WIDTH == 1) begin
              state_d = StFire;
              pcnt_d  = '0;
            end else begin
              state_d = StQual;
              qcnt_d  = QW'(1);
            end
          end
        end
        StQual: begin
          if (!s_in_q) begin
            state_d = StIdle;
            qcnt_d  = '0;
          end else if (qcnt_q == QLast) begin
            state_d = StFire;
            qcnt_d  = '0;
            pcnt_d  = '0;
          end else begin
            qcnt_d = qcnt_q + QW'(1);
          end
        end
        StFire: begin
          if (pcnt_q == PLast) begin
            pcnt_d  = '0;
            hcnt_d  = '0;
            state_d = (HOLDOFF == 0) ? StRearm : StHoldoff;
          end else begin
            pcnt_d = pcnt_q + PW'(1);
          end
        end
        StHoldoff: begin
          if (hcnt_q == HLast) begin
            hcnt_d  = '0;
            state_d = StRearm;
          end else begin
            hcnt_d = hcnt_q + HW'(1);
          end
        end
        StRearm: begin
          // A level held high past holdoff must drop before re-arming.
          if (!s_in_q) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign fire_evt = ((state_q == StIdle) || (state_q == StQual)) && (state_d == StFire);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      qcnt_q  <= '0;
      pcnt_q  <= '0;
      hcnt_q  <= '0;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      pcnt_q  <= pcnt_d;
      hcnt_q  <= hcnt_d;
      // Outputs decoded from the next state so they are true flop outputs
      // that track state_q exactly.
      trig_q  <= (state_d == StFire);
      busy_q  <= (state_d == StFire) || (state_d == StHoldoff) || (state_d == StRearm);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (CNT_CLR) begin
      // A clear coinciding with an event keeps that event.
      cnt_q <= fire_evt ? CNT_W'(1) : '0;
      ovf_q <= 1'b0;
    end else if (fire_evt) begin
      if (&cnt_q) ovf_q <= 1'b1;
      else        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign TRIG_OUT = trig_q;
  assign BUSY     = busy_q;
  assign EVT_CNT  = cnt_q;
  assign OVF      = ovf_q;

endmodule

// File: tb/tb_amp_out_discriminator.sv
// Directed bench for amp_out_discriminator. Two instances share all inputs:
// one with default parameters and one with a 2-bit event counter for the
// saturation scenario. Inputs change 1 time unit after a rising edge and
// outputs are sampled at the same point, so iteration e observes edge e.
module tb_amp_out_discriminator;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST, AMP_IN, ENABLE, CNT_CLR;
  logic        trig, busy, ovf;
  logic [15:0] cnt;
  logic        trig2, busy2, ovf2;
  logic [1:0]  cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  amp_out_discriminator dut (
    .CLK      (CLK),
    .RST      (RST),
    .AMP_IN   (AMP_IN),
    .ENABLE   (ENABLE),
    .CNT_CLR  (CNT_CLR),
    .TRIG_OUT (trig),
    .BUSY     (busy),
    .EVT_CNT  (cnt),
    .OVF      (ovf)
  );

  amp_out_discriminator #(.CNT_W(2)) dut_sat (
    .CLK      (CLK),
    .RST      (RST),
    .AMP_IN   (AMP_IN),
    .ENABLE   (ENABLE),
    .CNT_CLR  (CNT_CLR),
    .TRIG_OUT (trig2),
    .BUSY     (busy2),
    .EVT_CNT  (cnt2),
    .OVF      (ovf2)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; AMP_IN = 1'b0; ENABLE = 1'b1; CNT_CLR = 1'b0;
    repeat (3) tick();
    RST = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    do_reset();
    for (int e = 0; e < 30; e++) begin
      AMP_IN = (e < 3);
      tick();
    end
    n_tests++;
    if (cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL reset_precount: cnt=%0d expected 1", cnt);
    end
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      AMP_IN = ~AMP_IN;
      tick();
      n_tests++;
      if ({trig, busy, cnt, ovf} !== 19'd0 || {trig2, busy2, cnt2, ovf2} !== 5'd0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: trig=%b busy=%b cnt=%0d ovf=%b expected all 0",
                 i, trig, busy, cnt, ovf);
      end
    end
    RST = 1'b0;
    AMP_IN = 1'b0;
  endtask

  task automatic test_defaults();
    logic exp_t, exp_b;
    do_reset();
    for (int e = 0; e < 35; e++) begin
      AMP_IN = (e < 10);
      tick();
      exp_t = (e >= 4 && e <= 7);
      exp_b = (e >= 4 && e <= 24);
      n_tests++;
      if (trig !== exp_t) begin
        n_fail++;
        $display("FAIL defaults_trig edge %0d: got %b expected %b", e, trig, exp_t);
      end
      n_tests++;
      if (busy !== exp_b) begin
        n_fail++;
        $display("FAIL defaults_busy edge %0d: got %b expected %b", e, busy, exp_b);
      end
    end
    n_tests++;
    if (cnt !== 16'd1 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL defaults_count: cnt=%0d ovf=%b expected 1/0", cnt, ovf);
    end
  endtask

  task automatic test_level_held();
    logic exp_t, exp_b;
    do_reset();
    for (int e = 0; e < 50; e++) begin
      AMP_IN = (e < 40);
      tick();
      exp_t = (e >= 4 && e <= 7);
      exp_b = (e >= 4 && e <= 41);
      n_tests++;
      if (trig !== exp_t || busy !== exp_b) begin
        n_fail++;
        $display("FAIL level_held edge %0d: trig=%b busy=%b expected %b/%b",
                 e, trig, busy, exp_t, exp_b);
      end
    end
    n_tests++;
    if (cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL level_held_count: cnt=%0d expected 1", cnt);
    end
  endtask

  task automatic test_glitch();
    logic exp_t;
    do_reset();
    for (int e = 0; e < 20; e++) begin
      AMP_IN = (e < 2);
      tick();
      n_tests++;
      if (trig !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch_short edge %0d: trig=%b busy=%b expected 0/0", e, trig, busy);
      end
    end
    n_tests++;
    if (cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL glitch_short_count: cnt=%0d expected 0", cnt);
    end
    for (int e = 0; e < 30; e++) begin
      AMP_IN = (e < 3);
      tick();
      exp_t = (e >= 4 && e <= 7);
      n_tests++;
      if (trig !== exp_t) begin
        n_fail++;
        $display("FAIL glitch_min edge %0d: trig=%b expected %b", e, trig, exp_t);
      end
    end
    n_tests++;
    if (cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL glitch_min_count: cnt=%0d expected 1", cnt);
    end
  endtask

  task automatic test_holdoff();
    logic exp_t, exp_b;
    do_reset();
    for (int e = 0; e < 60; e++) begin
      AMP_IN = (e < 3) || (e >= 14 && e <= 18) || (e >= 30 && e <= 34);
      tick();
      exp_t = (e >= 4 && e <= 7) || (e >= 34 && e <= 37);
      exp_b = (e >= 4 && e <= 24) || (e >= 34 && e <= 54);
      n_tests++;
      if (trig !== exp_t || busy !== exp_b) begin
        n_fail++;
        $display("FAIL holdoff edge %0d: trig=%b busy=%b expected %b/%b",
                 e, trig, busy, exp_t, exp_b);
      end
      if (e == 29) begin
        n_tests++;
        if (cnt !== 16'd1) begin
          n_fail++;
          $display("FAIL holdoff_ignored_count: cnt=%0d expected 1", cnt);
        end
      end
    end
    n_tests++;
    if (cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL holdoff_rearm_count: cnt=%0d expected 2", cnt);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_c;
    do_reset();
    for (int ev = 1; ev <= 5; ev++) begin
      for (int e = 0; e < 30; e++) begin
        AMP_IN = (e < 3);
        tick();
      end
      exp_c = (ev >= 3) ? 2'd3 : 2'(ev);
      n_tests++;
      if (cnt2 !== exp_c || ovf2 !== (ev >= 4)) begin
        n_fail++;
        $display("FAIL sat_event %0d: cnt=%0d ovf=%b expected %0d/%b",
                 ev, cnt2, ovf2, exp_c, (ev >= 4));
      end
    end
    for (int e = 0; e < 30; e++) begin
      AMP_IN  = (e < 3);
      CNT_CLR = (e == 4);
      tick();
      if (e == 4) begin
        n_tests++;
        if (cnt2 !== 2'd1 || ovf2 !== 1'b0 || cnt !== 16'd1) begin
          n_fail++;
          $display("FAIL sat_clr_with_event: cnt2=%0d ovf2=%b cnt=%0d expected 1/0/1",
                   cnt2, ovf2, cnt);
        end
      end
    end
    CNT_CLR = 1'b0;
    for (int ev = 0; ev < 3; ev++) begin
      for (int e = 0; e < 30; e++) begin
        AMP_IN = (e < 3);
        tick();
      end
    end
    n_tests++;
    if (cnt2 !== 2'd3 || ovf2 !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_refill: cnt=%0d ovf=%b expected 3/1", cnt2, ovf2);
    end
    CNT_CLR = 1'b1;
    tick();
    CNT_CLR = 1'b0;
    n_tests++;
    if (cnt2 !== 2'd0 || ovf2 !== 1'b0 || cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL sat_clr_alone: cnt2=%0d ovf2=%b cnt=%0d expected 0/0/0", cnt2, ovf2, cnt);
    end
  endtask

  task automatic test_enable_drop();
    logic exp_t, exp_b;
    do_reset();
    for (int e = 0; e < 40; e++) begin
      AMP_IN = (e <= 20);
      ENABLE = !(e >= 6 && e <= 11);
      tick();
      exp_t = (e >= 4 && e <= 5) || (e >= 14 && e <= 17);
      exp_b = (e >= 4 && e <= 5) || (e >= 14 && e <= 34);
      n_tests++;
      if (trig !== exp_t || busy !== exp_b) begin
        n_fail++;
        $display("FAIL enable_drop edge %0d: trig=%b busy=%b expected %b/%b",
                 e, trig, busy, exp_t, exp_b);
      end
    end
    n_tests++;
    if (cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL enable_drop_count: cnt=%0d expected 2", cnt);
    end
  endtask

  initial begin
    RST = 1'b1; AMP_IN = 1'b0; ENABLE = 1'b1; CNT_CLR = 1'b0;
    test_reset();
    test_defaults();
    test_level_held();
    test_glitch();
    test_holdoff();
    test_saturation();
    test_enable_drop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
